// File: rtl/cpu_id_stage_p_if.sv
// ID/EX boundary bus: decode-side inputs, writeback port, stall controls and latched EX-side outputs.
// The stage itself uses the slave modport; the decode/EX environment uses master.
interface cpu_id_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int CTRL_W = 32
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]       current_pc;
  logic [DATA_W-1:0]       ins;
  logic                    valid_in;
  logic [CTRL_W-1:0]       ctrl_in;
  logic [NREAD*AW-1:0]     read_num;
  logic                    reg_write_en;
  logic [AW-1:0]           reg_write_num;
  logic [DATA_W-1:0]       reg_write_data;
  logic                    hold;
  logic                    bubble;
  logic                    flush;

  logic [DATA_W-1:0]       current_pc_id;
  logic [DATA_W-1:0]       ins_id;
  logic [CTRL_W-1:0]       ctrl_id;
  logic                    valid_id;
  logic [NREAD*AW-1:0]     read_num_id;
  logic [NREAD*DATA_W-1:0] read_data_id;
  logic [NREAD*DATA_W-1:0] read_data_rt;

  modport master (
    output current_pc, ins, valid_in, ctrl_in, read_num,
           reg_write_en, reg_write_num, reg_write_data,
           hold, bubble, flush,
    input  current_pc_id, ins_id, ctrl_id, valid_id, read_num_id,
           read_data_id, read_data_rt
  );

  modport slave (
    input  current_pc, ins, valid_in, ctrl_in, read_num,
           reg_write_en, reg_write_num, reg_write_data,
           hold, bubble, flush,
    output current_pc_id, ins_id, ctrl_id, valid_id, read_num_id,
           read_data_id, read_data_rt
  );
endinterface

// File: rtl/cpu_id_stage_p.sv
// ID/EX boundary: N-read-port register file plus the ID->EX latch with flush/hold/bubble control.
// Optional macro ID_WB_BYPASS_EN enables same-cycle write-through from the writeback port to the read ports.
module cpu_id_stage_p #(
  parameter int               DATA_W   = 32,
  parameter int               NREGS    = 32,
  parameter int               NREAD    = 2,
  parameter int               CTRL_W   = 32,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input logic             clk,
  input logic             clr,
  cpu_id_stage_p_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]       regs [NREGS];
  logic                    wr_hit;
  logic [NREAD*DATA_W-1:0] rd_rt;

  logic [DATA_W-1:0]       pc_p1;
  logic [DATA_W-1:0]       ins_p1;
  logic [CTRL_W-1:0]       ctrl_p1;
  logic                    vld_p1;
  logic [NREAD*AW-1:0]     rnum_p1;
  logic [NREAD*DATA_W-1:0] rdata_p1;

  assign wr_hit = bus.reg_write_en && (bus.reg_write_num != '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[bus.reg_write_num] <= bus.reg_write_data;
    end
  end

  // ---- stage p0: combinational operand read (register 0 is hardwired to zero)
  always_comb begin
    rd_rt = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (bus.read_num[k*AW +: AW] != '0) begin
        rd_rt[k*DATA_W +: DATA_W] = regs[bus.read_num[k*AW +: AW]];
`ifdef ID_WB_BYPASS_EN
        if (wr_hit && (bus.reg_write_num == bus.read_num[k*AW +: AW]))
          rd_rt[k*DATA_W +: DATA_W] = bus.reg_write_data;
`endif
      end
    end
  end

  assign bus.read_data_rt = rd_rt;

  // ---- stage p1: ID/EX latch; priority clr > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_p1    <= '0;
      ins_p1   <= '0;
      ctrl_p1  <= CTRL_NOP;
      vld_p1   <= 1'b0;
      rnum_p1  <= '0;
      rdata_p1 <= '0;
    end else if (bus.flush || (bus.bubble && !bus.hold)) begin
      pc_p1    <= bus.current_pc;
      ins_p1   <= '0;
      ctrl_p1  <= CTRL_NOP;
      vld_p1   <= 1'b0;
      rnum_p1  <= '0;
      rdata_p1 <= '0;
    end else if (bus.hold) begin
      // Frozen operands still track writebacks so EX sees fresh values on release.
      for (int k = 0; k < NREAD; k++) begin
        if (wr_hit && (bus.reg_write_num == rnum_p1[k*AW +: AW]))
          rdata_p1[k*DATA_W +: DATA_W] <= bus.reg_write_data;
      end
    end else begin
      pc_p1    <= bus.current_pc;
      ins_p1   <= bus.ins;
      ctrl_p1  <= bus.ctrl_in;
      vld_p1   <= bus.valid_in;
      rnum_p1  <= bus.read_num;
      rdata_p1 <= rd_rt;
    end
  end

  assign bus.current_pc_id = pc_p1;
  assign bus.ins_id        = ins_p1;
  assign bus.ctrl_id       = ctrl_p1;
  assign bus.valid_id      = vld_p1;
  assign bus.read_num_id   = rnum_p1;
  assign bus.read_data_id  = rdata_p1;
endmodule

// File: tb/tb_cpu_id_stage_p.sv
// Scoreboard bench for cpu_id_stage_p: directed steps queue expected latch/read results, a negedge monitor compares.
module tb_cpu_id_stage_p;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] R7_SAME = 32'hA5A5_A5A5;
  localparam logic [31:0] R3_SAME = 32'h0000_0033;
`else
  localparam logic [31:0] R7_SAME = 32'h0000_0011;
  localparam logic [31:0] R3_SAME = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   step = 0;
  int   checks = 0;
  int   errors = 0;

  cpu_id_stage_p_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .CTRL_W(32)) bus ();

  cpu_id_stage_p #(.DATA_W(32), .NREGS(32), .NREAD(2), .CTRL_W(32), .CTRL_NOP(NOP)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          tag;
    logic [63:0] rd;
  } rt_exp_t;

  typedef struct {
    int          due;
    int          tag;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] ctrl;
    logic        vld;
    logic [9:0]  rn;
    logic [63:0] rd;
  } id_exp_t;

  rt_exp_t rtq[$];
  id_exp_t idq[$];
  rt_exp_t re;
  id_exp_t ie;

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic vin,
                       input logic [31:0] ctrl, input logic [4:0] r0, input logic [4:0] r1);
    bus.current_pc = pc;
    bus.ins        = ins;
    bus.valid_in   = vin;
    bus.ctrl_in    = ctrl;
    bus.read_num   = {r1, r0};
  endtask

  task automatic wb(input logic we, input logic [4:0] n, input logic [31:0] d);
    bus.reg_write_en   = we;
    bus.reg_write_num  = n;
    bus.reg_write_data = d;
  endtask

  task automatic ctl(input logic h, input logic b, input logic f);
    bus.hold   = h;
    bus.bubble = b;
    bus.flush  = f;
  endtask

  task automatic exp_rt(input logic [31:0] d0, input logic [31:0] d1);
    rt_exp_t e;
    e.due = cyc;
    e.tag = step;
    e.rd  = {d1, d0};
    rtq.push_back(e);
  endtask

  task automatic exp_id(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ctrl,
                        input logic vld, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] d0, input logic [31:0] d1);
    id_exp_t e;
    e.due  = cyc + 1;
    e.tag  = step;
    e.pc   = pc;
    e.ins  = ins;
    e.ctrl = ctrl;
    e.vld  = vld;
    e.rn   = {r1, r0};
    e.rd   = {d1, d0};
    idq.push_back(e);
  endtask

  task automatic exp_nop(input logic [31:0] pc);
    exp_id(pc, 32'h0, NOP, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    step++;
  endtask

  always @(negedge clk) begin
    while (rtq.size() > 0 && rtq[0].due <= cyc) begin
      re = rtq.pop_front();
      checks++;
      if (re.due != cyc || bus.read_data_rt !== re.rd) begin
        errors++;
        $display("FAIL read_rt step %0d got %h required %h", re.tag, bus.read_data_rt, re.rd);
      end
    end
    while (idq.size() > 0 && idq[0].due <= cyc) begin
      ie = idq.pop_front();
      checks++;
      if (ie.due != cyc || bus.current_pc_id !== ie.pc || bus.ins_id !== ie.ins ||
          bus.ctrl_id !== ie.ctrl || bus.valid_id !== ie.vld ||
          bus.read_num_id !== ie.rn || bus.read_data_id !== ie.rd) begin
        errors++;
        $display("FAIL id_latch step %0d got pc=%h ins=%h ctrl=%h vld=%b rn=%h rd=%h required pc=%h ins=%h ctrl=%h vld=%b rn=%h rd=%h",
                 ie.tag, bus.current_pc_id, bus.ins_id, bus.ctrl_id, bus.valid_id,
                 bus.read_num_id, bus.read_data_id,
                 ie.pc, ie.ins, ie.ctrl, ie.vld, ie.rn, ie.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] rv;

    clr = 1'b1;
    ctl(0, 0, 0);
    wb(0, 5'd0, 32'h0);
    drive(32'hDEAD_0000, 32'hFFFF_FFFF, 1'b1, 32'h77, 5'd4, 5'd6);
    exp_nop(32'h0);
    tick();

    clr = 1'b0;
    wb(1, 5'd1, 32'h1111_1111);
    drive(32'h100, 32'hAAAA_5555, 1'b1, 32'h55, 5'd3, 5'd2);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h100, 32'hAAAA_5555, 32'h55, 1'b1, 5'd3, 5'd2, 32'h0, 32'h0);
    tick();

    wb(1, 5'd2, 32'h2222_2222);
    drive(32'h104, 32'h1, 1'b1, 32'h66, 5'd1, 5'd4);
    exp_rt(32'h1111_1111, 32'h0);
    exp_id(32'h104, 32'h1, 32'h66, 1'b1, 5'd1, 5'd4, 32'h1111_1111, 32'h0);
    tick();

    // reset with live state and a concurrent write that must be discarded
    clr = 1'b1;
    wb(1, 5'd5, 32'h0000_FFFF);
    drive(32'h108, 32'h2, 1'b1, 32'h9, 5'd2, 5'd5);
    exp_nop(32'h0);
    tick();

    clr = 1'b0;
    wb(0, 5'd0, 32'h0);
    for (int r = 1; r < 32; r++) begin
      a  = 5'(r);
      b  = a ^ 5'h1F;
      rv = 32'(r);
      drive(rv << 2, rv, rv[0], rv, a, b);
      exp_rt(32'h0, 32'h0);
      exp_id(rv << 2, rv, rv, rv[0], a, b, 32'h0, 32'h0);
      tick();
    end

    wb(1, 5'd5, 32'hDEAD_BEEF);
    drive(32'h200, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h200, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();

    wb(1, 5'd0, 32'h0000_1234);
    drive(32'h204, 32'h20, 1'b1, 32'h7, 5'd5, 5'd0);
    exp_rt(32'hDEAD_BEEF, 32'h0);
    exp_id(32'h204, 32'h20, 32'h7, 1'b1, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    tick();

    wb(0, 5'd0, 32'h0);
    drive(32'h208, 32'h24, 1'b1, 32'h8, 5'd0, 5'd5);
    exp_rt(32'h0, 32'hDEAD_BEEF);
    exp_id(32'h208, 32'h24, 32'h8, 1'b1, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);
    tick();

    wb(1, 5'd7, 32'h11);
    drive(32'h20C, 32'h28, 1'b0, 32'h0, 5'd0, 5'd0);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h20C, 32'h28, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();

    // writeback and dependent read in the same cycle
    wb(1, 5'd7, 32'hA5A5_A5A5);
    drive(32'h210, 32'h2C, 1'b1, 32'h9, 5'd5, 5'd7);
    exp_rt(32'hDEAD_BEEF, R7_SAME);
    exp_id(32'h210, 32'h2C, 32'h9, 1'b1, 5'd5, 5'd7, 32'hDEAD_BEEF, R7_SAME);
    tick();

    wb(0, 5'd0, 32'h0);
    drive(32'h214, 32'h30, 1'b1, 32'hA, 5'd7, 5'd7);
    exp_rt(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    exp_id(32'h214, 32'h30, 32'hA, 1'b1, 5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();

    wb(1, 5'd1, 32'h1001);
    drive(32'h218, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h218, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();

    wb(1, 5'd2, 32'h2002);
    drive(32'h21C, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h21C, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();

    wb(0, 5'd0, 32'h0);
    drive(32'h300, 32'h8C22_0004, 1'b1, 32'h23, 5'd1, 5'd2);
    exp_rt(32'h1001, 32'h2002);
    exp_id(32'h300, 32'h8C22_0004, 32'h23, 1'b1, 5'd1, 5'd2, 32'h1001, 32'h2002);
    tick();

    // three held cycles; only the r2 writeback refreshes a frozen operand
    ctl(1, 0, 0);
    wb(1, 5'd2, 32'h77);
    drive(32'h304, 32'hFFFF_FFFF, 1'b0, 32'h99, 5'd3, 5'd4);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h300, 32'h8C22_0004, 32'h23, 1'b1, 5'd1, 5'd2, 32'h1001, 32'h77);
    tick();

    ctl(1, 1, 0);
    wb(1, 5'd3, 32'h33);
    exp_rt(R3_SAME, 32'h0);
    exp_id(32'h300, 32'h8C22_0004, 32'h23, 1'b1, 5'd1, 5'd2, 32'h1001, 32'h77);
    tick();

    ctl(1, 0, 0);
    wb(1, 5'd9, 32'h99);
    exp_rt(32'h33, 32'h0);
    exp_id(32'h300, 32'h8C22_0004, 32'h23, 1'b1, 5'd1, 5'd2, 32'h1001, 32'h77);
    tick();

    ctl(0, 1, 0);
    wb(0, 5'd0, 32'h0);
    drive(32'h0040_0010, 32'h1234_5678, 1'b1, 32'hAB, 5'd1, 5'd2);
    exp_rt(32'h1001, 32'h77);
    exp_nop(32'h0040_0010);
    tick();

    ctl(0, 0, 0);
    drive(32'h480, 32'hBEEF, 1'b1, 32'h5, 5'd9, 5'd1);
    exp_rt(32'h99, 32'h1001);
    exp_id(32'h480, 32'hBEEF, 32'h5, 1'b1, 5'd9, 5'd1, 32'h99, 32'h1001);
    tick();

    ctl(1, 1, 1);
    wb(1, 5'd10, 32'hA0A0);
    drive(32'h500, 32'hCAFE, 1'b1, 32'h1, 5'd2, 5'd3);
    exp_rt(32'h77, 32'h33);
    exp_nop(32'h500);
    tick();

    ctl(0, 0, 0);
    wb(0, 5'd0, 32'h0);
    drive(32'h504, 32'h0BAD, 1'b1, 32'h42, 5'd10, 5'd10);
    exp_rt(32'hA0A0, 32'hA0A0);
    exp_id(32'h504, 32'h0BAD, 32'h42, 1'b1, 5'd10, 5'd10, 32'hA0A0, 32'hA0A0);
    tick();

    // reset while held
    ctl(1, 0, 0);
    clr = 1'b1;
    drive(32'h508, 32'h1, 1'b1, 32'h3, 5'd1, 5'd2);
    exp_nop(32'h0);
    tick();

    clr = 1'b0;
    ctl(0, 0, 0);
    drive(32'h50C, 32'h2, 1'b1, 32'h4, 5'd10, 5'd1);
    exp_rt(32'h0, 32'h0);
    exp_id(32'h50C, 32'h2, 32'h4, 1'b1, 5'd10, 5'd1, 32'h0, 32'h0);
    tick();

    drive(32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();

    checks++;
    if (rtq.size() != 0 || idq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending required 0/0", rtq.size(), idq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_id_stage_p.md
Name: cpu_id_stage_p

Overview:
Parametrised ID/EX boundary block: an internal register file with N read ports plus the ID→EX pipeline latch for PC, instruction, decoded controls and operands. It is the successor of the fixed 2-port, 32-bit decode latch. It adds a write-through bypass, a distinct hold (freeze) mode alongside bubble insertion, a valid bit, and operand refresh while held. It sits between the decode logic (which supplies read numbers and controls) and EX; writeback comes from MEM/WB.

Parameters:
DATA_W, 32, register/operand/PC/instruction width
NREGS, 32, number of architectural registers (power of 2, ≥2); localparam AW = $clog2(NREGS)
NREAD, 2, number of read ports (1..4)
CTRL_W, 32, width of the decoded control bundle
CTRL_NOP, 0, control value latched on bubble/flush/reset

Ports:
clk  in  1  global clock, all state on posedge
clr  in  1  synchronous active-high reset
current_pc  in  DATA_W  PC of the instruction in ID
ins  in  DATA_W  instruction in ID
valid_in  in  1  ID slot holds a real instruction
ctrl_in  in  CTRL_W  decoded controls for ins
read_num  in  NREAD*AW  packed read register numbers; port k = bits [k*AW +: AW]
reg_write_en  in  1  writeback enable from MEM/WB
reg_write_num  in  AW  writeback register
reg_write_data  in  DATA_W  writeback data
hold  in  1  freeze latch contents (downstream stall)
bubble  in  1  insert NOP into EX (load-use stall)
flush  in  1  kill ID instruction (branch/jump redirect)
current_pc_id  out  DATA_W  latched PC
ins_id  out  DATA_W  latched instruction
ctrl_id  out  CTRL_W  latched controls
valid_id  out  1  latched valid
read_num_id  out  NREAD*AW  latched read numbers
read_data_id  out  NREAD*DATA_W  latched operands, packed as read_num
read_data_rt  out  NREAD*DATA_W  combinational (same-cycle) read data, for hazard/forward logic

Behaviour:
- Regfile: NREGS x DATA_W array, written at posedge when reg_write_en && reg_write_num!=0. Register 0 reads 0 and is never written.
- Combinational read, port k: read_num[k]==0 → 0; otherwise bypass hit (see Optional Feature) → reg_write_data; otherwise array[read_num[k]].
- Latch update priority per posedge: clr > flush > hold > bubble > normal.
  - clr: all latch outputs = 0 (ctrl_id = CTRL_NOP, valid_id = 0); entire regfile zeroed; a write on the same edge is discarded.
  - flush: ctrl_id = CTRL_NOP, ins_id = 0, valid_id = 0, read_num_id = 0, read_data_id = 0; current_pc_id <= current_pc. Regfile writes proceed.
  - hold: every latch output retains its value except operand refresh. For each port k with reg_write_en && reg_write_num!=0 && reg_write_num==read_num_id[k], read_data_id[k] <= reg_write_data.
  - bubble: same as flush; current_pc_id <= current_pc.
  - normal: all latch outputs load their inputs; read_data_id[k] <= read_data_rt[k]; valid_id <= valid_in.
- Latency: 1 cycle from ID inputs to *_id outputs; read_data_rt has 0 latency.
- Simultaneous requests: flush+hold → flush wins (kills EX slot). hold+bubble → hold. Writes never stall.
- Multiple ports may name the same register; each resolves independently and identically.
- Reset mid-hold: clr overrides; first post-reset cycle behaves as normal.

Optional Feature:
Macro ID_WB_BYPASS_EN.
- Defined: a read whose read_num[k] equals reg_write_num while reg_write_en && reg_write_num!=0 returns reg_write_data in the same cycle (write-through), so a WB and a dependent ID may share a cycle.
- Undefined: read returns the pre-write array value; external forwarding must cover the 1-cycle gap. The hold-mode refresh is present in both builds.

Test Plan:
- clr for 1 cycle after random state → all *_id = 0, valid_id = 0, ctrl_id = CTRL_NOP; reading r1..r31 gives 0.
- Write r5 = 0xDEADBEEF, next cycle read_num port0 = 5, valid_in = 1 → read_data_id[0] = 0xDEADBEEF one cycle later; write r0 = 0x1234 → r0 reads 0.
- Same cycle: write r7 = 0xA5A5A5A5 and read port1 = 7 (old r7 = 0x11) → read_data_id[1] = 0xA5A5A5A5 with ID_WB_BYPASS_EN, 0x11 without.
- Latch ins = 0x8C220004 reading r1/r2, assert hold 3 cycles while writing r2 = 0x77 → ins_id unchanged, read_data_id[1] = 0x77, read_data_id[0] unchanged.
- bubble with valid_in = 1, pc = 0x400010 → valid_id = 0, ins_id = 0, ctrl_id = CTRL_NOP, current_pc_id = 0x400010.
- flush+hold+bubble together → flush result; next cycle all low → normal load resumes.
